block_map_ctrl: RTL and testbench



---
 rtl/block_map_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_block_map_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_map_ctrl.sv
// Residency controller: tag table of SD blocks held in SRAM slots, hit/miss lookup,
// round-robin victim choice and one swap transaction per miss. BLOCK_MAP_FLUSH_EN adds dirty flush.
module block_map_ctrl #(
  parameter int NumSlots  = 4,
  parameter int AddrWidth = 21,
  localparam int SlotW    = $clog2(NumSlots)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // Lookup handshake: a lookup transfers on a cycle with lookup_valid_i && lookup_ready_o;
  // the requester holds valid/addr/write until then, and gets exactly one resp_valid_o pulse back.
  input  logic                 lookup_valid_i,
  output logic                 lookup_ready_o,
  input  logic [AddrWidth-1:0] lookup_addr_i,
  input  logic                 lookup_write_i,
  output logic                 resp_valid_o,
  output logic [SlotW-1:0]     resp_slot_o,
  output logic                 resp_miss_o,
  output logic                 busy_o,
  output logic                 swap_req_o,
  output logic [SlotW-1:0]     swap_old_idx_o,
  output logic [AddrWidth-1:0] swap_old_addr_o,
  output logic [AddrWidth-1:0] swap_new_addr_o,
  output logic                 swap_load_only_o,
  input  logic                 swap_done_i,
  input  logic                 flush_i,
  output logic                 flush_done_o,
  output logic [2:0]           dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4,
    S_FSCAN = 3'd5,
    S_FWAIT = 3'd6
  } state_e;

  localparam logic [SlotW-1:0] LastIdx = SlotW'(NumSlots - 1);

  state_e               state_q, state_d;
  logic [NumSlots-1:0]  valid_q, dirty_q;
  logic [AddrWidth-1:0] tag_q [NumSlots];
  logic [SlotW-1:0]     rr_ptr_q;
  logic [AddrWidth-1:0] req_addr_q;
  logic                 req_write_q;
  logic                 from_rr_q;
  logic                 swap_req_q;
  logic [SlotW-1:0]     swap_old_idx_q;
  logic [AddrWidth-1:0] swap_old_addr_q, swap_new_addr_q;
  logic                 swap_load_only_q;
  logic [SlotW-1:0]     resp_slot_q;
  logic                 resp_miss_q;
  logic                 flush_go;

`ifdef BLOCK_MAP_FLUSH_EN
  logic [SlotW-1:0] scan_idx_q;
  logic             flush_done_q;
  logic             scan_dirty;
  assign flush_go     = flush_i;
  assign scan_dirty   = valid_q[scan_idx_q] && dirty_q[scan_idx_q];
  assign flush_done_o = flush_done_q;
`else
  logic unused_flush;
  assign flush_go     = 1'b0;
  assign unused_flush = flush_i;
  assign flush_done_o = 1'b0;
`endif

  // Parallel tag compare plus lowest-index free slot search.
  logic             hit, has_free;
  logic [SlotW-1:0] hit_idx, free_idx, victim;
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    has_free = 1'b0;
    free_idx = '0;
    for (int i = NumSlots - 1; i >= 0; i--) begin
      if (valid_q[i] && (tag_q[i] == req_addr_q)) begin
        hit     = 1'b1;
        hit_idx = SlotW'(i);
      end
      if (!valid_q[i]) begin
        has_free = 1'b1;
        free_idx = SlotW'(i);
      end
    end
  end
  assign victim = has_free ? free_idx : rr_ptr_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (flush_go) state_d = S_FSCAN;
               else if (lookup_valid_i) state_d = S_CHECK;
      S_CHECK: state_d = hit ? S_RESP : S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (swap_done_i) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
`ifdef BLOCK_MAP_FLUSH_EN
      S_FSCAN: if (scan_dirty) state_d = S_FWAIT;
               else if (scan_idx_q == LastIdx) state_d = S_IDLE;
      S_FWAIT: if (swap_done_i) state_d = (scan_idx_q == LastIdx) ? S_IDLE : S_FSCAN;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= S_IDLE;
      valid_q          <= '0;
      dirty_q          <= '0;
      for (int i = 0; i < NumSlots; i++) tag_q[i] <= '0;
      rr_ptr_q         <= '0;
      req_addr_q       <= '0;
      req_write_q      <= 1'b0;
      from_rr_q        <= 1'b0;
      swap_req_q       <= 1'b0;
      swap_old_idx_q   <= '0;
      swap_old_addr_q  <= '0;
      swap_new_addr_q  <= '0;
      swap_load_only_q <= 1'b0;
      resp_slot_q      <= '0;
      resp_miss_q      <= 1'b0;
`ifdef BLOCK_MAP_FLUSH_EN
      scan_idx_q       <= '0;
      flush_done_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      swap_req_q <= 1'b0;
`ifdef BLOCK_MAP_FLUSH_EN
      flush_done_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (lookup_valid_i && lookup_ready_o) begin
            req_addr_q  <= lookup_addr_i;
            req_write_q <= lookup_write_i;
          end
`ifdef BLOCK_MAP_FLUSH_EN
          if (flush_go) scan_idx_q <= '0;
`endif
        end
        S_CHECK: begin
          if (hit) begin
            resp_slot_q <= hit_idx;
            resp_miss_q <= 1'b0;
            if (req_write_q) dirty_q[hit_idx] <= 1'b1;
          end else begin
            // Swap fields are latched here so they are stable from ISSUE through WAIT.
            swap_old_idx_q   <= victim;
            swap_old_addr_q  <= tag_q[victim];
            swap_new_addr_q  <= req_addr_q;
            swap_load_only_q <= !valid_q[victim] || !dirty_q[victim];
            from_rr_q        <= !has_free;
            swap_req_q       <= 1'b1;
          end
        end
        S_WAIT: begin
          if (swap_done_i) begin
            tag_q[swap_old_idx_q]   <= req_addr_q;
            valid_q[swap_old_idx_q] <= 1'b1;
            dirty_q[swap_old_idx_q] <= req_write_q;
            if (from_rr_q) rr_ptr_q <= (rr_ptr_q == LastIdx) ? '0 : rr_ptr_q + 1'b1;
            resp_slot_q <= swap_old_idx_q;
            resp_miss_q <= 1'b1;
          end
        end
`ifdef BLOCK_MAP_FLUSH_EN
        S_FSCAN: begin
          if (scan_dirty) begin
            // Write-back in place: old and new address are the same tag.
            swap_old_idx_q   <= scan_idx_q;
            swap_old_addr_q  <= tag_q[scan_idx_q];
            swap_new_addr_q  <= tag_q[scan_idx_q];
            swap_load_only_q <= 1'b0;
            swap_req_q       <= 1'b1;
          end else if (scan_idx_q == LastIdx) begin
            flush_done_q <= 1'b1;
          end else begin
            scan_idx_q <= scan_idx_q + 1'b1;
          end
        end
        S_FWAIT: begin
          if (swap_done_i) begin
            dirty_q[scan_idx_q] <= 1'b0;
            if (scan_idx_q == LastIdx) flush_done_q <= 1'b1;
            else scan_idx_q <= scan_idx_q + 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign lookup_ready_o   = (state_q == S_IDLE) && !flush_go;
  assign busy_o           = (state_q != S_IDLE);
  assign resp_valid_o     = (state_q == S_RESP);
  assign resp_slot_o      = resp_slot_q;
  assign resp_miss_o      = resp_miss_q;
  assign swap_req_o       = swap_req_q;
  assign swap_old_idx_o   = swap_old_idx_q;
  assign swap_old_addr_o  = swap_old_addr_q;
  assign swap_new_addr_o  = swap_new_addr_q;
  assign swap_load_only_o = swap_load_only_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_block_map_ctrl.sv
// Directed bench for block_map_ctrl: scoreboard queues of expected swaps and responses.
// Flush steps compile when BLOCK_MAP_FLUSH_EN is defined, otherwise the flush-ignored steps run.
module tb_block_map_ctrl;
  localparam int NS  = 4;
  localparam int AW  = 21;
  localparam int SW  = 2;
  localparam int SWW = SW + 2 * AW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          lookup_valid = 1'b0, lookup_write = 1'b0;
  logic [AW-1:0] lookup_addr = '0;
  logic          lookup_ready, resp_valid, resp_miss, busy, swap_req, swap_load_only;
  logic [SW-1:0] resp_slot, swap_old_idx;
  logic [AW-1:0] swap_old_addr, swap_new_addr;
  logic          swap_done = 1'b0, flush = 1'b0, flush_done;
  logic [2:0]    dbg_state;

  int errors = 0;
  int checks = 0;
  logic [SW:0]     exp_q[$];
  logic [SWW-1:0]  exp_swap_q[$];

  block_map_ctrl #(.NumSlots(NS), .AddrWidth(AW)) dut (
    .clk_i(clk), .rst_i(rst),
    .lookup_valid_i(lookup_valid), .lookup_ready_o(lookup_ready),
    .lookup_addr_i(lookup_addr), .lookup_write_i(lookup_write),
    .resp_valid_o(resp_valid), .resp_slot_o(resp_slot), .resp_miss_o(resp_miss),
    .busy_o(busy), .swap_req_o(swap_req), .swap_old_idx_o(swap_old_idx),
    .swap_old_addr_o(swap_old_addr), .swap_new_addr_o(swap_new_addr),
    .swap_load_only_o(swap_load_only), .swap_done_i(swap_done),
    .flush_i(flush), .flush_done_o(flush_done), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_swap();
    logic [SWW-1:0] es;
    chk("swap_q_nonempty", exp_swap_q.size() != 0, 1);
    if (exp_swap_q.size() != 0) begin
      es = exp_swap_q.pop_front();
      chk("swap_idx", swap_old_idx, es[SWW-1 -: SW]);
      chk("swap_new", swap_new_addr, es[AW:1]);
      chk("swap_load_only", swap_load_only, es[0]);
      if (!es[0]) chk("swap_old", swap_old_addr, es[2*AW:AW+1]);
    end
  endtask

  task automatic pulse_done(input int dly);
    repeat (dly) @(posedge clk);
    #1 swap_done = 1'b1;
    @(posedge clk);
    #1 swap_done = 1'b0;
  endtask

  // One lookup; expectations are queued before the request is driven.
  task automatic lookup(input logic [AW-1:0] addr, input logic wr, input int dly, input logic stray,
                        input logic exp_miss, input logic [SW-1:0] exp_slot,
                        input logic [AW-1:0] exp_old, input logic exp_lo);
    logic        got;
    logic        after_done;
    logic [SW:0] er;
    if (exp_miss) exp_swap_q.push_back({exp_slot, exp_old, addr, exp_lo});
    exp_q.push_back({exp_miss, exp_slot});
    @(posedge clk); #1;
    lookup_valid = 1'b1; lookup_addr = addr; lookup_write = wr;
    @(negedge clk);
    chk("ready_idle", lookup_ready, 1);
    @(posedge clk); #1;
    lookup_valid = 1'b0; lookup_write = 1'b0;
    if (stray) swap_done = 1'b1;
    got = 1'b0;
    after_done = 1'b0;
    for (int c = 1; c <= 100 && !got; c++) begin
      @(negedge clk);
      if (after_done) begin
        chk("miss_resp_lat", resp_valid, 1);
        after_done = 1'b0;
      end
      if (!exp_miss) chk("hit_no_swap", swap_req, 0);
      if (resp_valid) begin
        got = 1'b1;
        chk("resp_q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          er = exp_q.pop_front();
          chk("resp_slot", resp_slot, er[SW-1:0]);
          chk("resp_miss", resp_miss, er[SW]);
        end
        if (!exp_miss) chk("hit_lat", c, 2);
      end else if (exp_miss && swap_req) begin
        chk("swap_lat", c, 2);
        chk("busy_swap", busy, 1);
        check_swap();
        pulse_done(dly);
        after_done = 1'b1;
      end
      if (stray && c == 1) begin
        @(posedge clk);
        #1 swap_done = 1'b0;
      end
    end
    chk("resp_seen", got, 1);
    @(negedge clk);
    chk("resp_one_cycle", resp_valid, 0);
    chk("ready_after", lookup_ready, 1);
  endtask

  initial begin
    logic found;
    int   nswap;
    logic fdone;
    logic [SW:0] er;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_swap_req", swap_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_resp_slot", resp_slot, 0);
    chk("rst_swap_idx", swap_old_idx, 0);
    chk("rst_swap_new", swap_new_addr, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_state", dbg_state, 0);
    @(posedge clk); #1 rst = 1'b0;

    // First miss, then write hit on the same block
    lookup(21'h10, 1'b0, 3, 1'b0, 1'b1, 2'd0, 21'h0, 1'b1);
    lookup(21'h10, 1'b1, 1, 1'b0, 1'b0, 2'd0, 21'h0, 1'b0);
    // Fill remaining slots, done as early as the cycle after swap_req
    lookup(21'h11, 1'b0, 1, 1'b0, 1'b1, 2'd1, 21'h0, 1'b1);
    lookup(21'h12, 1'b0, 2, 1'b0, 1'b1, 2'd2, 21'h0, 1'b1);
    lookup(21'h13, 1'b0, 1, 1'b0, 1'b1, 2'd3, 21'h0, 1'b1);

    // Stray done in IDLE, then in CHECK of a hit
    @(posedge clk); #1 swap_done = 1'b1;
    @(posedge clk); #1 swap_done = 1'b0;
    @(negedge clk);
    chk("stray_idle_busy", busy, 0);
    chk("stray_idle_state", dbg_state, 0);
    chk("stray_idle_resp", resp_valid, 0);
    lookup(21'h11, 1'b0, 1, 1'b1, 1'b0, 2'd1, 21'h0, 1'b0);

    // Round-robin evictions: dirty slot 0 first, wrap after slot 3
    lookup(21'h20, 1'b0, 2, 1'b0, 1'b1, 2'd0, 21'h10, 1'b0);
    lookup(21'h21, 1'b1, 1, 1'b0, 1'b1, 2'd1, 21'h11, 1'b1);
    lookup(21'h22, 1'b0, 1, 1'b0, 1'b1, 2'd2, 21'h12, 1'b1);
    lookup(21'h23, 1'b0, 4, 1'b0, 1'b1, 2'd3, 21'h13, 1'b1);
    lookup(21'h24, 1'b0, 1, 1'b0, 1'b1, 2'd0, 21'h20, 1'b1);
    lookup(21'h25, 1'b0, 1, 1'b0, 1'b1, 2'd1, 21'h21, 1'b0);

    // Reset while waiting for the swap engine
    exp_swap_q.push_back({2'd2, 21'h22, 21'h30, 1'b1});
    @(posedge clk); #1 lookup_valid = 1'b1; lookup_addr = 21'h30;
    @(posedge clk); #1 lookup_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (swap_req) found = 1'b1;
    end
    chk("rst_swap_seen", found, 1);
    if (found) check_swap();
    @(posedge clk); #1;
    @(negedge clk);
    chk("wait_busy", busy, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_state", dbg_state, 0);
    chk("midrst_swap_req", swap_req, 0);
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_swap_idx", swap_old_idx, 0);
    chk("midrst_swap_old", swap_old_addr, 0);
    chk("midrst_swap_new", swap_new_addr, 0);
    chk("midrst_load_only", swap_load_only, 0);
    chk("midrst_resp_miss", resp_miss, 0);
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    exp_swap_q.delete();
    lookup(21'h24, 1'b0, 2, 1'b0, 1'b1, 2'd0, 21'h0, 1'b1);

`ifdef BLOCK_MAP_FLUSH_EN
    // Make slots 1 and 3 dirty, then flush racing a lookup
    lookup(21'h41, 1'b1, 1, 1'b0, 1'b1, 2'd1, 21'h0, 1'b1);
    lookup(21'h42, 1'b0, 1, 1'b0, 1'b1, 2'd2, 21'h0, 1'b1);
    lookup(21'h43, 1'b1, 1, 1'b0, 1'b1, 2'd3, 21'h0, 1'b1);
    exp_swap_q.push_back({2'd1, 21'h41, 21'h41, 1'b0});
    exp_swap_q.push_back({2'd3, 21'h43, 21'h43, 1'b0});
    exp_q.push_back({1'b0, 2'd0});
    @(posedge clk); #1;
    flush = 1'b1; lookup_valid = 1'b1; lookup_addr = 21'h24; lookup_write = 1'b0;
    @(negedge clk);
    chk("flush_wins_ready", lookup_ready, 0);
    @(posedge clk); #1 flush = 1'b0;
    nswap = 0;
    fdone = 1'b0;
    for (int c = 0; c < 200 && !fdone; c++) begin
      @(negedge clk);
      if (flush_done) fdone = 1'b1;
      else begin
        chk("flush_ready_low", lookup_ready, 0);
        if (swap_req) begin
          nswap++;
          check_swap();
          pulse_done(2);
        end
      end
    end
    chk("flush_done_seen", fdone, 1);
    chk("flush_swaps", nswap, 2);
    chk("flush_then_ready", lookup_ready, 1);
    @(posedge clk); #1 lookup_valid = 1'b0;
    @(negedge clk);
    chk("flush_done_pulse", flush_done, 0);
    @(negedge clk);
    chk("post_flush_resp", resp_valid, 1);
    if (exp_q.size() != 0) begin
      er = exp_q.pop_front();
      chk("post_flush_slot", resp_slot, er[SW-1:0]);
      chk("post_flush_miss", resp_miss, er[SW]);
    end
    // Second flush finds nothing dirty and takes NS scan cycles
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    fdone = 1'b0;
    for (int c = 1; c <= 50 && !fdone; c++) begin
      @(negedge clk);
      chk("empty_flush_no_swap", swap_req, 0);
      if (flush_done) begin
        fdone = 1'b1;
        chk("empty_flush_lat", c, NS + 1);
      end
    end
    chk("empty_flush_done", fdone, 1);
`else
    // Flush request must be ignored
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("noflush_swap", swap_req, 0);
      chk("noflush_done", flush_done, 0);
      chk("noflush_busy", busy, 0);
    end
`endif

    chk("resp_q_drained", exp_q.size(), 0);
    chk("swap_q_drained", exp_swap_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit");
  end
endmodule
